// File: rtl/tri_raster_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tri_raster_pkg
// Purpose  : State encoding and small helpers shared by the triangle rasteriser.
// Revision : 1.0
// ============================================================================
package tri_raster_pkg;

    localparam int c_state_w = 4;

    localparam logic [c_state_w-1:0] c_st_idle  = 4'd0;
    localparam logic [c_state_w-1:0] c_st_load  = 4'd1;
    localparam logic [c_state_w-1:0] c_st_sort0 = 4'd2;
    localparam logic [c_state_w-1:0] c_st_sort1 = 4'd3;
    localparam logic [c_state_w-1:0] c_st_sort2 = 4'd4;
    localparam logic [c_state_w-1:0] c_st_setup = 4'd5;
    localparam logic [c_state_w-1:0] c_st_row   = 4'd6;
    localparam logic [c_state_w-1:0] c_st_span  = 4'd7;
    localparam logic [c_state_w-1:0] c_st_done  = 4'd8;

    function automatic int acc_width(input int cw);
        return 2 * cw + 1;
    endfunction

    function automatic logic signed [31:0] smin(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_edge_walker.sv
`default_nettype none
// ============================================================================
// Module   : tri_edge_walker
// Purpose  : Incremental edge x tracker; x truncates toward zero as y advances.
// Revision : 1.0
// ============================================================================
module tri_edge_walker
    import tri_raster_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic signed [CW-1:0] i_xs,
    input  logic signed [CW-1:0] i_ys,
    input  logic signed [CW-1:0] i_xe,
    input  logic signed [CW-1:0] i_ye,
    input  logic                 i_step,
    input  logic signed [CW:0]   i_target_y,
    output logic signed [CW-1:0] o_x,
    output logic                 o_settled
);

    localparam int c_acc_w = acc_width(CW);

    logic signed [c_acc_w-1:0] r_err;
    logic signed [c_acc_w-1:0] r_dy;
    logic signed [c_acc_w-1:0] r_adx;
    logic signed [CW:0]        r_y;
    logic signed [CW-1:0]      r_x;
    logic                      r_neg;

    logic signed [c_acc_w-1:0] w_dx;
    logic signed [c_acc_w-1:0] w_dy;
    logic                      w_need_x;

    assign w_dx = c_acc_w'(i_xe) - c_acc_w'(i_xs);
    assign w_dy = c_acc_w'(i_ye) - c_acc_w'(i_ys);

    // A horizontal edge (dy = 0) never steps: its x stays at the start vertex.
    assign w_need_x  = (r_dy != '0) && (r_err >= r_dy);
    assign o_settled = (r_y >= i_target_y) && !w_need_x;
    assign o_x       = r_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_err <= '0;
            r_dy  <= '0;
            r_adx <= '0;
            r_neg <= 1'b0;
        end else if (i_load) begin
            r_x   <= i_xs;
            r_y   <= (CW+1)'(i_ys);
            r_err <= '0;
            r_dy  <= w_dy;
            r_adx <= w_dx[c_acc_w-1] ? -w_dx : w_dx;
            r_neg <= w_dx[c_acc_w-1];
        end else if (i_step) begin
            if (w_need_x) begin
                r_x   <= r_neg ? r_x - CW'(1) : r_x + CW'(1);
                r_err <= r_err - r_dy;
            end else if (r_y < i_target_y) begin
                r_y   <= r_y + (CW+1)'(1);
                r_err <= r_err + r_adx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tri_raster_stream.sv
`default_nettype none
// ============================================================================
// Module   : tri_raster_stream
// Purpose  : Filled-triangle rasteriser emitting covered pixels as a stream.
//            Define TRI_RASTER_CLIP_EN to clip rows/spans to the screen.
// Revision : 1.0
// ============================================================================
module tri_raster_stream
    import tri_raster_pkg::*;
#(
    parameter int CW       = 12,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int COLOR_W  = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [CW-1:0] x0,
    input  logic signed [CW-1:0] y0,
    input  logic signed [CW-1:0] x1,
    input  logic signed [CW-1:0] y1,
    input  logic signed [CW-1:0] x2,
    input  logic signed [CW-1:0] y2,
    input  logic [COLOR_W-1:0]   color,
    output logic                 busy,
    output logic                 done,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic [XW-1:0]        px_x,
    output logic [YW-1:0]        px_y,
    output logic [COLOR_W-1:0]   px_color
);

`ifdef TRI_RASTER_CLIP_EN
    localparam logic c_clip_en = 1'b1;
`else
    localparam logic c_clip_en = 1'b0;
`endif
    localparam logic signed [CW:0] c_scr_w = (CW+1)'(SCREEN_W);
    localparam logic signed [CW:0] c_scr_h = (CW+1)'(SCREEN_H);

    logic [c_state_w-1:0] r_state, w_next;
    logic signed [CW-1:0] r_xa, r_ya, r_xb, r_yb, r_xc, r_yc;
    logic [COLOR_W-1:0]   r_color;
    logic signed [CW:0]   r_y;
    logic signed [CW-1:0] r_x, r_r;
    logic                 r_upper;

    logic signed [CW-1:0] w_long_x, w_short_x;
    logic signed [CW-1:0] w_sxs, w_sys, w_sxe, w_sye;
    logic signed [CW:0]   w_lx, w_rx, w_l, w_r;
    logic w_long_ok, w_short_ok, w_use_ab, w_short_load;
    logic w_reload, w_row_ready, w_last_row, w_skip, w_degen;

    assign w_degen     = (r_ya == r_yc);
    assign w_last_row  = (r_y >= (CW+1)'(r_yc));
    assign w_reload    = r_upper && (r_y >= (CW+1)'(r_yb));
    assign w_row_ready = !w_reload && w_long_ok && w_short_ok;

    // The short edge starts on a->b only when that edge spans at least one row.
    assign w_use_ab     = (r_state == c_st_setup) && (r_yb > r_ya);
    assign w_short_load = (r_state == c_st_setup) || ((r_state == c_st_row) && w_reload);
    assign w_sxs = w_use_ab ? r_xa : r_xb;
    assign w_sys = w_use_ab ? r_ya : r_yb;
    assign w_sxe = w_use_ab ? r_xb : r_xc;
    assign w_sye = w_use_ab ? r_yb : r_yc;

    assign w_lx = w_degen ? (CW+1)'(smin(smin(32'(r_xa), 32'(r_xb)), 32'(r_xc)))
                          : (CW+1)'(smin(32'(w_long_x), 32'(w_short_x)));
    assign w_rx = w_degen ? (CW+1)'(smax(smax(32'(r_xa), 32'(r_xb)), 32'(r_xc)))
                          : (CW+1)'(smax(32'(w_long_x), 32'(w_short_x)));

    assign w_skip = c_clip_en && (r_y[CW] || (r_y >= c_scr_h) || w_rx[CW] || (w_lx >= c_scr_w));
    assign w_l    = (c_clip_en && w_lx[CW]) ? '0 : w_lx;
    assign w_r    = (c_clip_en && (w_rx >= c_scr_w)) ? c_scr_w - (CW+1)'(1) : w_rx;

    tri_edge_walker #(.CW(CW)) u_long (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (r_state == c_st_setup),
        .i_xs       (r_xa),
        .i_ys       (r_ya),
        .i_xe       (r_xc),
        .i_ye       (r_yc),
        .i_step     (r_state == c_st_row),
        .i_target_y (r_y),
        .o_x        (w_long_x),
        .o_settled  (w_long_ok)
    );

    tri_edge_walker #(.CW(CW)) u_short (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_short_load),
        .i_xs       (w_sxs),
        .i_ys       (w_sys),
        .i_xe       (w_sxe),
        .i_ye       (w_sye),
        .i_step     (r_state == c_st_row),
        .i_target_y (r_y),
        .o_x        (w_short_x),
        .o_settled  (w_short_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_st_idle;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (start) w_next = c_st_load;
            c_st_load:  w_next = c_st_sort0;
            c_st_sort0: w_next = c_st_sort1;
            c_st_sort1: w_next = c_st_sort2;
            c_st_sort2: w_next = c_st_setup;
            c_st_setup: w_next = c_st_row;
            c_st_row: begin
                if (w_row_ready) begin
                    if (!w_skip)        w_next = c_st_span;
                    else if (w_last_row) w_next = c_st_done;
                end
            end
            c_st_span:  if (px_ready && (r_x == r_r)) w_next = w_last_row ? c_st_done : c_st_row;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        px_valid = 1'b0;
        case (r_state)
            c_st_idle: ;
            c_st_done: done = 1'b1;
            c_st_span: begin
                busy     = 1'b1;
                px_valid = 1'b1;
            end
            default:   busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xa <= '0; r_ya <= '0; r_xb <= '0; r_yb <= '0; r_xc <= '0; r_yc <= '0;
            r_color <= '0;
            r_y     <= '0;
            r_x     <= '0;
            r_r     <= '0;
            r_upper <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: if (start) begin
                    r_xa <= x0; r_ya <= y0; r_xb <= x1; r_yb <= y1; r_xc <= x2; r_yc <= y2;
                    r_color <= color;
                end
                // Strict compares keep tied vertices in input order.
                c_st_sort0, c_st_sort2: if (r_yb < r_ya) begin
                    r_xa <= r_xb; r_ya <= r_yb; r_xb <= r_xa; r_yb <= r_ya;
                end
                c_st_sort1: if (r_yc < r_yb) begin
                    r_xb <= r_xc; r_yb <= r_yc; r_xc <= r_xb; r_yc <= r_yb;
                end
                c_st_setup: begin
                    r_y     <= (CW+1)'(r_ya);
                    r_upper <= (r_yb > r_ya);
                end
                c_st_row: begin
                    if (w_reload) begin
                        r_upper <= 1'b0;
                    end else if (w_row_ready) begin
                        if (w_skip) begin
                            r_y <= r_y + (CW+1)'(1);
                        end else begin
                            r_x <= CW'(w_l);
                            r_r <= CW'(w_r);
                        end
                    end
                end
                c_st_span: if (px_ready) begin
                    if (r_x == r_r) r_y <= r_y + (CW+1)'(1);
                    else            r_x <= r_x + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign px_x     = r_x[XW-1:0];
    assign px_y     = r_y[YW-1:0];
    assign px_color = r_color;

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_stream.sv
`default_nettype none
// Directed bench for tri_raster_stream: pixel stream compared against a
// closed-form edge model plus hand-computed spans.
module tb_tri_raster_stream;

    localparam int CW = 12;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int COLOR_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic px_ready = 1'b0;
    logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [COLOR_W-1:0] color = '0;
    logic busy, done, px_valid;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic [COLOR_W-1:0] px_color;

    int n_checks = 0;
    int n_fail = 0;
    int got_x[$], got_y[$], exp_x[$], exp_y[$];
    int done_cnt;
    bit stall_seen;

    tri_raster_stream dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .color(color), .busy(busy), .done(done),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_x(px_x), .px_y(px_y), .px_color(px_color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int edge_at(input int xs, input int ys, input int xe, input int ye, input int y);
        int dy, dx, adx, q;
        dy = ye - ys;
        dx = xe - xs;
        if (dy == 0) return xs;
        adx = (dx < 0) ? -dx : dx;
        q = ((y - ys) * adx) / dy;
        return (dx < 0) ? xs - q : xs + q;
    endfunction

    task automatic build_model(input int ax, input int ay, input int bx, input int by, input int cx, input int cy);
        int t;
        exp_x.delete();
        exp_y.delete();
        if (by < ay) begin t = ax; ax = bx; bx = t; t = ay; ay = by; by = t; end
        if (cy < by) begin t = bx; bx = cx; cx = t; t = by; by = cy; cy = t; end
        if (by < ay) begin t = ax; ax = bx; bx = t; t = ay; ay = by; by = t; end
        for (int y = ay; y <= cy; y++) begin
            int l, r, el, es;
            if (ay == cy) begin
                l = (ax < bx) ? ax : bx; l = (l < cx) ? l : cx;
                r = (ax > bx) ? ax : bx; r = (r > cx) ? r : cx;
            end else begin
                el = edge_at(ax, ay, cx, cy, y);
                es = (y < by) ? edge_at(ax, ay, bx, by, y) : edge_at(bx, by, cx, cy, y);
                l = (el < es) ? el : es;
                r = (el > es) ? el : es;
            end
`ifdef TRI_RASTER_CLIP_EN
            if (y < 0 || y >= 480 || r < 0 || l >= 640) continue;
            if (l < 0) l = 0;
            if (r > 639) r = 639;
`endif
            for (int x = l; x <= r; x++) begin
                exp_x.push_back(x & ((1 << XW) - 1));
                exp_y.push_back(y & ((1 << YW) - 1));
            end
        end
    endtask

    task automatic drive_tri(input int ax, input int ay, input int bx, input int by, input int cx, input int cy, input int col);
        x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by); x2 = CW'(cx); y2 = CW'(cy);
        color = COLOR_W'(col);
    endtask

    task automatic run_tri(input string tag, input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int col, input bit stall25);
        int cycles, post, stall_left, hx, hy, hc;
        bit stalled;
        cycles = 0; post = 0; stalled = 0;
        stall_left = stall25 ? 3 : 0;
        got_x.delete(); got_y.delete();
        done_cnt = 0;
        @(negedge clk);
        drive_tri(ax, ay, bx, by, cx, cy, col);
        start = 1'b1;
        px_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, int'(busy), 1);
        while (cycles < 4000 && post < 4) begin
            if (px_valid && stall_left > 0 && int'(px_x) == 25) begin
                if (!stalled) begin
                    stalled = 1; stall_seen = 1;
                    hx = int'(px_x); hy = int'(px_y); hc = int'(px_color);
                end else begin
                    check({tag, "_hold_x"}, int'(px_x), hx);
                    check({tag, "_hold_y"}, int'(px_y), hy);
                    check({tag, "_hold_color"}, int'(px_color), hc);
                end
                px_ready = 1'b0;
                stall_left--;
            end else begin
                px_ready = 1'b1;
            end
            if (px_valid && px_ready) begin
                if (got_x.size() == 0) check({tag, "_color"}, int'(px_color), col);
                got_x.push_back(int'(px_x));
                got_y.push_back(int'(px_y));
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) check({tag, "_busy_at_done"}, int'(busy), 0);
            end
            if (done_cnt > 0) post++;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_no_timeout"}, int'(cycles < 4000), 1);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle_valid"}, int'(px_valid), 0);
    endtask

    task automatic compare_model(input string tag);
        int f0;
        check({tag, "_count"}, got_x.size(), exp_x.size());
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            f0 = n_fail;
            check($sformatf("%s_px%0d_x", tag, i), got_x[i], exp_x[i]);
            check($sformatf("%s_px%0d_y", tag, i), got_y[i], exp_y[i]);
            if (n_fail != f0) break;
        end
    endtask

    task automatic row_span(input int y, output int first, output int last, output int n);
        first = -1; last = -1; n = 0;
        for (int i = 0; i < got_y.size(); i++) begin
            if (got_y[i] == y) begin
                if (n == 0) first = got_x[i];
                last = got_x[i];
                n++;
            end
        end
    endtask

    initial begin
        int f, l, n, cycles;
        stall_seen = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(px_valid), 0);
        check("rst_px_x", int'(px_x), 0);
        check("rst_px_y", int'(px_y), 0);
        check("rst_color", int'(px_color), 0);
        reset = 1'b1;

        build_model(35, 40, 10, 20, 30, 60);
        run_tri("t1", 35, 40, 10, 20, 30, 60, 'hA5, 1'b0);
        compare_model("t1");
        row_span(20, f, l, n);
        check("t1_r20_first", f, 10); check("t1_r20_last", l, 10); check("t1_r20_n", n, 1);
        row_span(40, f, l, n);
        check("t1_r40_first", f, 20); check("t1_r40_last", l, 35); check("t1_r40_n", n, 16);
        row_span(60, f, l, n);
        check("t1_r60_first", f, 30); check("t1_r60_last", l, 30); check("t1_r60_n", n, 1);

        build_model(0, 0, 4, 0, 0, 4);
        run_tri("t2", 0, 0, 4, 0, 0, 4, 'h3C, 1'b0);
        compare_model("t2");
        check("t2_total", got_x.size(), 15);
        row_span(0, f, l, n);
        check("t2_r0_first", f, 0); check("t2_r0_last", l, 4);
        row_span(3, f, l, n);
        check("t2_r3_last", l, 1);

        build_model(7, 5, 2, 5, 9, 5);
        run_tri("t3", 7, 5, 2, 5, 9, 5, 'h11, 1'b0);
        compare_model("t3");
        row_span(5, f, l, n);
        check("t3_first", f, 2); check("t3_last", l, 9); check("t3_total", got_x.size(), 8);

        build_model(35, 40, 10, 20, 30, 60);
        run_tri("t4", 35, 40, 10, 20, 30, 60, 'h5A, 1'b1);
        compare_model("t4");
        check("t4_stall_seen", int'(stall_seen), 1);

        // Abort a triangle mid-span with reset, then run a fresh one.
        @(negedge clk);
        drive_tri(35, 40, 10, 20, 30, 60, 'h77);
        start = 1'b1; px_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!(px_valid && int'(px_y) == 40) && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        check("t5_reached_span", int'(px_valid), 1);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", int'(px_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        check("t5_hold_valid", int'(px_valid), 0);
        reset = 1'b1;
        build_model(0, 0, 4, 0, 0, 4);
        run_tri("t5", 0, 0, 4, 0, 0, 4, 'h42, 1'b0);
        compare_model("t5");
        check("t5_total", got_x.size(), 15);

`ifdef TRI_RASTER_CLIP_EN
        build_model(-10, 0, 10, 0, -10, 0);
        run_tri("c1", -10, 0, 10, 0, -10, 0, 'h99, 1'b0);
        compare_model("c1");
        check("c1_total", got_x.size(), 11);
        row_span(0, f, l, n);
        check("c1_first", f, 0); check("c1_last", l, 10);

        build_model(-20, 3, -5, 3, -8, 3);
        run_tri("c2", -20, 3, -5, 3, -8, 3, 'h66, 1'b0);
        check("c2_total", got_x.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tri_raster_stream.md
Name: tri_raster_stream

Overview:
- Parametrised successor to the current filled-triangle filler. Takes three signed vertices on a start pulse and emits every covered pixel as a valid/ready stream, row by row, bottom-y to top-y, left to right.
- Edge x positions are computed incrementally (no per-row divide, no 640-entry X arrays).
- Left/right is resolved per row. Flat and degenerate triangles are handled.
- Sits between the command decoder and the framebuffer write port, with a colour tag passed through.

Parameters:
- CW, 12, signed vertex coordinate width.
- XW, 10, output pixel x width.
- YW, 9, output pixel y width.
- COLOR_W, 8, colour tag width.
- SCREEN_W, 640, visible columns (used by clipping).
- SCREEN_H, 480, visible rows (used by clipping).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x0,y0,x1,y1,x2,y2  in  CW each  signed vertices.
- color  in  COLOR_W  fill colour.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- px_valid  out  1  pixel available.
- px_ready  in  1  downstream accept.
- px_x  out  XW  pixel x.
- px_y  out  YW  pixel y.
- px_color  out  COLOR_W  latched colour.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - busy, done, px_valid = 0; px_x, px_y, px_color = 0.
  - Effective mid-operation: the current triangle is abandoned and no further pixels are emitted.
- State machine: IDLE -> LOAD -> SORT0 -> SORT1 -> SORT2 -> SETUP -> ROW -> SPAN -> (ROW | DONE) -> IDLE.
- LOAD: latch vertices and colour; busy = 1. A start while busy is ignored.
- SORT0..2: three compare-swap steps. Result is ya <= yb <= yc. Ties keep input order (stable sort).
- SETUP: initialise two edge walkers.
  - Long edge: a->c.
  - Short edge: a->b while y < yb; b->c for y >= yb.
  - Accumulators are 2*CW+1 bits wide.
- Edge x at row y = xs + sign(dx) * floor((y - ys) * |dx| / dy), i.e. truncation toward zero. If dy = 0, edge x = xs.
- ROW: advance walkers to the current y. Each cycle moves x by ±1 while the error term is >= dy, so shallow edges take multiple ROW cycles. When settled, L = min(xlong, xshort) and R = max(xlong, xshort).
- Degenerate case (ya = yc): single row from min(x0,x1,x2) to max(x0,x1,x2).
- SPAN: emit x = L..R inclusive at row y.
  - px_valid stays high until each handshake.
  - px_x, px_y, px_color hold stable while px_valid && !px_ready.
  - One pixel per cycle at full throughput.
  - After R is accepted: y++. Next state is ROW if y <= yc, else DONE.
- Per-row latency: 1 cycle plus walker steps before the first pixel of the row.
- DONE: done = 1 for one cycle, busy = 0, then IDLE. The earliest next start is accepted the cycle after done.
- Output truncation: px_x / px_y are the low XW / YW bits of the coordinate.
- Without clipping, vertices must lie within [0, SCREEN_W-1] x [0, SCREEN_H-1].

Optional Feature:
- TRI_RASTER_CLIP_EN defined:
  - Rows with y < 0 or y >= SCREEN_H are walked but emit nothing.
  - L and R are clamped to [0, SCREEN_W-1]. A span with R < 0 or L >= SCREEN_W emits nothing.
  - A fully offscreen triangle still asserts done.
- Not defined: no clamping or skipping. Out-of-range coordinates are truncated, and any such stimulus is unsupported.

Decomposition:
- Shared package tri_raster_pkg:
  - State enum localparams (IDLE..DONE).
  - Accumulator width function 2*CW+1.
  - Min/max helper functions.
- One sub-module: tri_edge_walker.
  - Loads (xs, ys, xe, ye).
  - Advances toward a target y on a step request.
  - Outputs current x and a settled flag.
  - Instantiated twice (long edge and short edge). The short-edge instance is reloaded with b->c at y = yb.

Test Plan:
- (35,40),(10,20),(30,60) with px_ready=1 -> expected rows:
  - row 20: single pixel x=10;
  - row 40: x=20..35 (16 px);
  - row 60: single pixel x=30;
  - rows strictly increasing, x increasing within each row, done exactly once.
- (0,0),(4,0),(0,4) -> rows 0..4 with spans 0..4, 0..3, 0..2, 0..1, 0..0; 15 pixels total.
- (7,5),(2,5),(9,5) degenerate -> single row 5, x=2..9, 8 pixels, then done.
- Same as the first case but px_ready low for 3 cycles while px_x=25 -> px_x/px_y/px_color held constant, pixel 25 emitted exactly once, total pixel count unchanged.
- Pull reset low during a SPAN -> px_valid, busy, done = 0 immediately. After release, a new start with (0,0),(4,0),(0,4) yields exactly 15 pixels.
- With TRI_RASTER_CLIP_EN: (-10,0),(10,0),(-10,0) -> row 0, x=0..10 (11 px). (-20,3),(-5,3),(-8,3) -> 0 pixels, done still pulses.
